// File: rtl/uart_pkg.sv
// Shared UART types: TX/RX state encodings, CON status bit positions, default divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // 100 MHz system clock / 9600 baud
    localparam int unsigned BAUD_DIV_DEFAULT = 10417;

    // Bit positions inside the CON status word
    localparam int TX_DONE  = 0;
    localparam int RX_VALID = 1;
    localparam int TX_BUSY  = 2;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_if.sv
// Bus-side register interface of the UART: TXD write strobe, CON read strobe, status/data readback.
// Latency: n/a (wires only).
// Backpressure: none; a start strobe while busy is dropped by the slave.
interface uart_if;
    logic [7:0] i_tx_data;
    logic       i_tx_start;
    logic       i_con_read;
    logic [7:0] o_rx_data;
    logic [7:0] o_tx_data;
    logic [2:0] o_con;

    modport master (
        output i_tx_data, i_tx_start, i_con_read,
        input  o_rx_data, o_tx_data, o_con
    );

    modport slave (
        input  i_tx_data, i_tx_start, i_con_read,
        output o_rx_data, o_tx_data, o_con
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; done pulses in the last cycle of a loaded interval of load_val cycles.
// Latency: done is high load_val cycles after the load edge (reload on done for back-to-back bits).
// Backpressure: none; load always wins over counting.
module uart_bit_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        done
);
    logic [15:0] cnt_q, cnt_d;

    // next count: reload, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    // counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= 16'd0;
        else       cnt_q <= cnt_d;
    end

    // count of one means the interval ends at the coming edge
    assign done = (cnt_q == 16'd1);
endmodule

// File: rtl/uart_controller.sv
// 8N1 UART transmitter/receiver with sticky done/valid status cleared by a CON read.
// Latency: TX line drops one edge after start; RX byte lands ~3 cycles after the mid-stop sample.
// Backpressure: start strobes while busy are ignored; new RX bytes overwrite unread ones.
module uart_controller
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  i_uart_rx,
    output logic  o_uart_tx,
    uart_if.slave bus
);
    localparam logic [15:0] BIT_LEN  = 16'(BAUD_DIV);
    localparam logic [15:0] HALF_LEN = 16'(BAUD_DIV / 2);

    tx_state_e   tx_state_q, tx_state_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic        tx_line_q, tx_line_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_busy_q, tx_busy_d;
    logic        tx_done_q, tx_done_d;
    logic        tx_done_set, tx_load, tx_tick;

    logic [1:0]  sync_q, sync_d;
    logic        rx_s;
    rx_state_e   rx_state_q, rx_state_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_ferr_q, rx_ferr_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_valid_set, rx_load, rx_tick;
    logic [15:0] rx_load_val;

    uart_bit_timer u_tx_timer (
        .clk(clk), .reset(reset), .load(tx_load), .load_val(BIT_LEN), .done(tx_tick)
    );

    uart_bit_timer u_rx_timer (
        .clk(clk), .reset(reset), .load(rx_load), .load_val(rx_load_val), .done(rx_tick)
    );

    assign rx_s   = sync_q[1];
    assign sync_d = {sync_q[0], i_uart_rx};

    // TX frame sequencing: start bit, 8 data bits LSB first, stop bit
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_idx_d    = tx_idx_q;
        tx_line_d   = tx_line_q;
        tx_data_d   = tx_data_q;
        tx_busy_d   = tx_busy_q;
        tx_done_set = 1'b0;
        tx_load     = 1'b0;
        case (tx_state_q)
            TX_IDLE: if (bus.i_tx_start) begin
                tx_data_d  = bus.i_tx_data;
                tx_state_d = TX_START;
                tx_line_d  = 1'b0;
                tx_busy_d  = 1'b1;
                tx_load    = 1'b1;
            end
            TX_START: if (tx_tick) begin
                tx_state_d = TX_DATA;
                tx_idx_d   = 3'd0;
                tx_line_d  = tx_data_q[0];
                tx_load    = 1'b1;
            end
            TX_DATA: if (tx_tick) begin
                tx_load = 1'b1;
                if (tx_idx_q == 3'd7) begin
                    tx_state_d = TX_STOP;
                    tx_line_d  = 1'b1;
                end else begin
                    tx_idx_d  = tx_idx_q + 3'd1;
                    tx_line_d = tx_data_q[tx_idx_d];
                end
            end
            TX_STOP: if (tx_tick) begin
                tx_state_d  = TX_IDLE;
                tx_busy_d   = 1'b0;
                tx_done_set = 1'b1;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RX frame sampling: half-bit start check, mid-bit data samples, stop check
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_idx_d     = rx_idx_q;
        rx_shift_d   = rx_shift_q;
        rx_ferr_d    = rx_ferr_q;
        rx_data_d    = rx_data_q;
        rx_valid_set = 1'b0;
        rx_load      = 1'b0;
        rx_load_val  = BIT_LEN;
        case (rx_state_q)
            RX_IDLE: if (!rx_s) begin
                rx_state_d  = RX_START;
                rx_load     = 1'b1;
                rx_load_val = HALF_LEN;
            end
            RX_START: if (rx_tick) begin
                if (!rx_s) begin
                    rx_state_d = RX_DATA;
                    rx_idx_d   = 3'd0;
                    rx_load    = 1'b1;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_DATA: if (rx_tick) begin
                rx_shift_d = {rx_s, rx_shift_q[7:1]};
                rx_load    = 1'b1;
                if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
                else                  rx_idx_d   = rx_idx_q + 3'd1;
            end
            RX_STOP: begin
                // after a framing error, hold here until the line returns high
                if (rx_ferr_q) begin
                    if (rx_s) begin
                        rx_state_d = RX_IDLE;
                        rx_ferr_d  = 1'b0;
                    end
                end else if (rx_tick) begin
                    if (rx_s) begin
                        rx_data_d    = rx_shift_q;
                        rx_valid_set = 1'b1;
                        rx_state_d   = RX_IDLE;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // sticky status flags: a set in the same cycle as a CON read wins
    always_comb begin
        tx_done_d  = tx_done_set  | (tx_done_q  & ~bus.i_con_read);
        rx_valid_d = rx_valid_set | (rx_valid_q & ~bus.i_con_read);
    end

    // all state registers; reset returns line idle-high and both FSMs to IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_idx_q   <= 3'd0;
            tx_line_q  <= 1'b1;
            tx_data_q  <= 8'h00;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            sync_q     <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_idx_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_ferr_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_idx_q   <= tx_idx_d;
            tx_line_q  <= tx_line_d;
            tx_data_q  <= tx_data_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
            sync_q     <= sync_d;
            rx_state_q <= rx_state_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign o_uart_tx          = tx_line_q;
    assign bus.o_tx_data      = tx_data_q;
    assign bus.o_rx_data      = rx_data_q;
    assign bus.o_con[TX_DONE]  = tx_done_q;
    assign bus.o_con[RX_VALID] = rx_valid_q;
    assign bus.o_con[TX_BUSY]  = tx_busy_q;
endmodule

// File: tb/tb_uart_controller.sv
// Bench for uart_controller at BAUD_DIV=16: vector tables, corner sequences, random TX/RX traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_controller;
    localparam int B = 16;

    logic clk = 1'b0;
    logic reset;
    logic i_uart_rx;
    logic o_uart_tx;

    uart_if bus();

    uart_controller #(.BAUD_DIV(B)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_uart_rx(i_uart_rx),
        .o_uart_tx(o_uart_tx),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model state: last good byte and the RX valid flag
    logic [7:0] m_rx_data = 8'h00;
    logic       m_rx_valid = 1'b0;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       clr_first;
        logic [7:0] exp_data;
        logic       exp_valid;
    } rx_vec_t;

    typedef struct {
        logic [7:0] d;
        int         inject_at;
        logic [7:0] inj;
    } tx_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // line level k cycles into a frame: start bit, data LSB first, stop bit
    function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int k);
        int bit_no;
        logic [7:0] sh;
        bit_no = k / B;
        if (bit_no == 0) return 1'b0;
        if (bit_no <= 8) begin
            sh = d >> (bit_no - 1);
            return sh[0];
        end
        return stop;
    endfunction

    task automatic con_read();
        bus.i_con_read = 1'b1;
        step();
        bus.i_con_read = 1'b0;
    endtask

    task automatic tx_frame(input logic [7:0] d, input int inject_at, input logic [7:0] inj,
                            input string tag);
        int wave_err;
        int busy_err;
        wave_err = 0;
        busy_err = 0;
        bus.i_tx_data  = d;
        bus.i_tx_start = 1'b1;
        step();
        bus.i_tx_start = 1'b0;
        for (int k = 0; k < 10 * B; k++) begin
            if (o_uart_tx !== frame_bit(d, 1'b1, k)) wave_err++;
            if (bus.o_con[2] !== 1'b1) busy_err++;
            if (k == inject_at) begin
                bus.i_tx_data  = inj;
                bus.i_tx_start = 1'b1;
            end
            step();
            bus.i_tx_start = 1'b0;
        end
        check({tag, " wave_errs"}, wave_err, 0);
        check({tag, " busy_errs"}, busy_err, 0);
        check({tag, " busy_end"}, {31'd0, bus.o_con[2]}, 0);
        check({tag, " done_end"}, {31'd0, bus.o_con[0]}, 1);
        check({tag, " tx_data"}, {24'd0, bus.o_tx_data}, {24'd0, d});
    endtask

    // sends one frame; outcome is checked 3 cycles after the mid-stop-bit point
    task automatic rx_frame(input logic [7:0] d, input logic stop, input int read_at,
                            input logic [7:0] exp_data, input logic exp_valid, input string tag);
        for (int k = 0; k < 10 * B; k++) begin
            i_uart_rx      = frame_bit(d, stop, k);
            bus.i_con_read = (k == read_at);
            if (k == 9 * B + B / 2 + 3) begin
                check({tag, " rx_data"}, {24'd0, bus.o_rx_data}, {24'd0, exp_data});
                check({tag, " rx_valid"}, {31'd0, bus.o_con[1]}, {31'd0, exp_valid});
            end
            step();
        end
        bus.i_con_read = 1'b0;
        i_uart_rx = 1'b1;
        repeat (20) step();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_vec_t rx_tab[6];
        tx_vec_t tx_tab[5];
        logic [7:0] rd, td;
        logic rs;

        rx_tab[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1};
        rx_tab[1] = '{8'h55, 1'b0, 1'b1, 8'h3C, 1'b0};
        rx_tab[2] = '{8'h12, 1'b1, 1'b0, 8'h12, 1'b1};
        rx_tab[3] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
        rx_tab[4] = '{8'h00, 1'b0, 1'b0, 8'hFF, 1'b1};
        rx_tab[5] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1};

        tx_tab[0] = '{8'hA5, -1,  8'h00};
        tx_tab[1] = '{8'hA5, 40,  8'hFF};
        tx_tab[2] = '{8'h00, -1,  8'h00};
        tx_tab[3] = '{8'hFF, -1,  8'h00};
        tx_tab[4] = '{8'h3C, 150, 8'h11};

        reset = 1'b1;
        i_uart_rx = 1'b1;
        bus.i_tx_data = 8'h00;
        bus.i_tx_start = 1'b0;
        bus.i_con_read = 1'b0;
        repeat (3) step();
        check("reset tx_line", {31'd0, o_uart_tx}, 1);
        check("reset rx_data", {24'd0, bus.o_rx_data}, 0);
        check("reset tx_data", {24'd0, bus.o_tx_data}, 0);
        check("reset con", {29'd0, bus.o_con}, 0);
        reset = 1'b0;
        repeat (3) step();

        // TX with clean status: CON must read exactly tx_done afterwards
        tx_frame(8'hA5, -1, 8'h00, "tx_a5_clean");
        check("tx_a5 con", {29'd0, bus.o_con}, 32'd1);

        foreach (tx_tab[i]) begin
            con_read();
            tx_frame(tx_tab[i].d, tx_tab[i].inject_at, tx_tab[i].inj, $sformatf("tx_tab%0d", i));
        end
        con_read();
        check("con_read clears tx_done", {31'd0, bus.o_con[0]}, 0);

        foreach (rx_tab[i]) begin
            if (rx_tab[i].clr_first) con_read();
            rx_frame(rx_tab[i].d, rx_tab[i].stop, -1, rx_tab[i].exp_data, rx_tab[i].exp_valid,
                     $sformatf("rx_tab%0d", i));
        end
        m_rx_data = 8'h81;

        con_read();
        check("con_read clears rx_valid", {31'd0, bus.o_con[1]}, 0);

        // short low glitch is a false start
        i_uart_rx = 1'b0;
        repeat (4) step();
        i_uart_rx = 1'b1;
        repeat (30) step();
        check("glitch rx_data", {24'd0, bus.o_rx_data}, {24'd0, m_rx_data});
        check("glitch con", {29'd0, bus.o_con}, 0);
        rx_frame(8'h6B, 1'b1, -1, 8'h6B, 1'b1, "after_glitch");
        m_rx_data = 8'h6B;

        // CON read in the same cycle rx_valid sets: set wins
        con_read();
        rx_frame(8'hC3, 1'b1, 9 * B + B / 2 + 2, 8'hC3, 1'b1, "read_same_cycle");
        m_rx_data = 8'hC3;

        // random concurrent TX and RX traffic
        for (int n = 0; n < 6; n++) begin
            td = 8'($urandom);
            rd = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            con_read();
            m_rx_valid = 1'b0;
            if (rs) begin
                m_rx_data  = rd;
                m_rx_valid = 1'b1;
            end
            fork
                tx_frame(td, -1, 8'h00, $sformatf("rand_tx%0d", n));
                rx_frame(rd, rs, -1, m_rx_data, m_rx_valid, $sformatf("rand_rx%0d", n));
            join
        end

        // reset in the middle of a TX frame (line low during data bit 3 of 0xA5 is bit=0)
        bus.i_tx_data  = 8'hA5;
        bus.i_tx_start = 1'b1;
        step();
        bus.i_tx_start = 1'b0;
        repeat (70) step();
        check("mid_tx line before reset", {31'd0, o_uart_tx}, {31'd0, frame_bit(8'hA5, 1'b1, 70)});
        reset = 1'b1;
        #1;
        check("mid_tx reset line", {31'd0, o_uart_tx}, 1);
        check("mid_tx reset con", {29'd0, bus.o_con}, 0);
        check("mid_tx reset tx_data", {24'd0, bus.o_tx_data}, 0);
        check("mid_tx reset rx_data", {24'd0, bus.o_rx_data}, 0);
        repeat (5) step();
        check("reset held line", {31'd0, o_uart_tx}, 1);
        reset = 1'b0;
        repeat (20) step();
        check("after reset line idle", {31'd0, o_uart_tx}, 1);
        check("after reset con", {29'd0, bus.o_con}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_controller.md
UART_CONTROLLER -- requirements
Module: uart_controller

Interface
REQ-001 Parameter BAUD_DIV, default 10417, clk cycles per bit (100 MHz / 9600 baud); legal range 4..65535.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 i_uart_rx  input  1  serial receive line, idle high, asynchronous to clk.
REQ-005 o_uart_tx  output  1  serial transmit line, idle high.
REQ-006 i_tx_data  input  8  byte to transmit.
REQ-007 i_tx_start  input  1  one-cycle pulse from a bus write to UART_TXD (0x40000018).
REQ-008 i_con_read  input  1  one-cycle pulse from a bus read of UART_CON (0x40000020).
REQ-009 o_rx_data  output  8  last correctly framed received byte; feeds the peripheral controller's rxd input.
REQ-010 o_tx_data  output  8  byte currently held for transmission; feeds the peripheral controller's txd input.
REQ-011 o_con  output  3  status: [0] tx_done (sticky), [1] rx_valid (sticky), [2] tx_busy (live).

Function
REQ-012 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity; every bit lasts exactly BAUD_DIV cycles.
REQ-013 TX FSM states: IDLE, START, DATA, STOP; a per-bit cycle counter and a 3-bit index drive the state changes.
REQ-014 IDLE + i_tx_start: latch i_tx_data into o_tx_data, enter START; o_uart_tx goes low and tx_busy goes high on the next clock edge.
REQ-015 START->DATA after BAUD_DIV cycles; DATA shifts bits 0..7, each held BAUD_DIV cycles; after bit 7 enter STOP and drive 1.
REQ-016 STOP->IDLE after BAUD_DIV cycles; on that edge tx_busy clears and tx_done sets; total frame time is 10*BAUD_DIV cycles.
REQ-017 i_tx_start while tx_busy=1 is ignored: o_tx_data and the frame in progress are unchanged.
REQ-018 i_uart_rx passes through a 2-flop synchronizer before use; the RX FSM sees only the synchronized value.
REQ-019 RX FSM states: IDLE, START, DATA, STOP.
REQ-020 IDLE: on a synchronized low, enter START.
REQ-021 START: after BAUD_DIV/2 cycles, resample; low -> DATA; high -> false start, return to IDLE.
REQ-022 DATA: sample every BAUD_DIV cycles (mid-bit); shift in 8 bits LSB first; then enter STOP.
REQ-023 STOP: sample after BAUD_DIV cycles. If 1: load o_rx_data and set rx_valid on the same edge. If 0: framing error; discard the byte, leave o_rx_data and rx_valid unchanged, and wait in STOP until the line is high, then enter IDLE.
REQ-024 i_con_read clears tx_done and rx_valid on the next edge; a set and a clear of the same flag in one cycle leave the flag set.
REQ-025 A new received byte overwrites o_rx_data even if rx_valid is already set (no overrun flag).
REQ-026 TX and RX run independently; simultaneous activity is legal.
REQ-027 All outputs are registered; no combinational path runs from inputs to outputs.

Reset
REQ-028 On reset assertion: o_uart_tx=1, o_rx_data=0x00, o_tx_data=0x00, o_con=3'b000, both FSMs IDLE, counters 0, synchronizer flops 1.
REQ-029 Reset mid-frame aborts the frame immediately with no partial stop bit; o_uart_tx is high while reset is held.

Structure
REQ-030 The shared package uart_pkg holds: the TX/RX state enums, the CON bit index constants (TX_DONE=0, RX_VALID=1, TX_BUSY=2) and the default BAUD_DIV.
REQ-031 One sub-module, uart_bit_timer (a loadable down-counter with a terminal pulse), is instantiated once for TX and once for RX.

Verification (BAUD_DIV=16)
REQ-032 Pulse i_tx_start with i_tx_data=0xA5 -> o_uart_tx is 0 for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles; o_con[2]=1 for exactly 160 cycles, then o_con=3'b001.
REQ-033 Drive serial 0x3C on i_uart_rx -> o_rx_data=0x3C and o_con[1]=1 within 3 cycles of the mid-stop-bit sample; a following i_con_read pulse -> o_con[1]=0.
REQ-034 Drive a low glitch of 4 cycles on i_uart_rx -> RX returns to IDLE; o_rx_data and o_con are unchanged.
REQ-035 Drive a frame of 0x55 with stop bit 0 -> o_rx_data keeps its prior value and o_con[1] stays 0; a subsequent valid 0x12 is received correctly.
REQ-036 Pulse i_tx_start with 0xFF 40 cycles into a 0xA5 frame -> ignored; the line waveform and o_tx_data=0xA5 are unchanged.
REQ-037 i_con_read in the same cycle rx_valid sets -> o_con[1]=1; assert reset 70 cycles into a TX frame -> o_uart_tx=1 and o_con=0 immediately.
